// File: rtl/imem_fetch_unit_if.sv
// imem_fetch_unit_if: fetch-side bundle (control, imem read port, decode handshake, redirect)
//   master = fetch unit: drives imem_addr, out_valid, out_instr, out_pc
//   slave  = environment: drives start, stop, imem_data, out_ready, redirect_valid, redirect_pc
interface imem_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  modport master (
    input  start, stop, imem_data, out_ready, redirect_valid, redirect_pc,
    output imem_addr, out_valid, out_instr, out_pc
  );
  modport slave (
    output start, stop, imem_data, out_ready, redirect_valid, redirect_pc,
    input  imem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: PC owner and instruction fetcher with a small prefetch FIFO toward decode
//   clk, rst : clock, asynchronous active-high reset
//   bus      : imem_fetch_unit_if.master (start/stop, imem_addr/imem_data, out_* handshake, redirect_*)
module imem_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0,
  parameter int DEPTH    = 2
) (
  input logic clk,
  input logic rst,
  imem_fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [ADDR_W-1:0] pc, pc_next, redir_pc, jump_pc;
  logic [DATA_W-1:0] buf_instr [DEPTH];
  logic [ADDR_W-1:0] buf_pc [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic push, pop, jump;
  assign bus.imem_addr = pc;
  assign bus.out_valid = count != '0;
  assign bus.out_instr = buf_instr[rd_ptr];
  assign bus.out_pc    = buf_pc[rd_ptr];
  assign redir_pc = bus.redirect_pc & ~ADDR_W'(3);
  assign jump_pc  = {bus.imem_data[ADDR_W-3:0], 2'b00};
  always_comb begin
    state_next = (state == IDLE && bus.start) ? RUN : (state == RUN && bus.stop) ? IDLE : state;
    // a redirect cancels both sides of the handshake, so the discarded head is never counted as consumed
    pop  = bus.out_valid & bus.out_ready & ~bus.redirect_valid;
    push = (state == RUN) & ~bus.stop & ~bus.redirect_valid & ((count != CNT_W'(DEPTH)) | pop);
    jump = bus.imem_data[DATA_W-1 -: 6] == 6'b000010;
    pc_next = bus.redirect_valid ? redir_pc : push ? (jump ? jump_pc : pc + ADDR_W'(4)) : pc;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= ADDR_W'(RESET_PC);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else begin
      pc <= pc_next;
      if (bus.redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(pop);
        wr_ptr <= wr_ptr + PTR_W'(push);
        count  <= count + CNT_W'(push) - CNT_W'(pop);
      end
      if (push) begin
        buf_instr[wr_ptr] <= bus.imem_data;
        buf_pc[wr_ptr]    <= pc;
      end
    end
  end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: directed checks of fetch streaming, backpressure, jumps, redirects, wrap and reset
module tb_imem_fetch_unit;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  logic seen48 = 0;
  logic [7:0] acc [$];
  imem_fetch_unit_if #(.ADDR_W(8), .DATA_W(32)) bus();
  imem_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  // memory returns its own address as data, except a jump to 24 stored at 44
  assign bus.imem_data = (bus.imem_addr == 8'd44) ? 32'h0800_0006 : {24'b0, bus.imem_addr};
  always @(posedge clk)
    if (!rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) acc.push_back(bus.out_pc);
  always @(negedge clk)
    if (bus.imem_addr == 8'd48) seen48 = 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_rst();
    rst = 1;
    #1;
    rst = 0;
  endtask
  function automatic logic [31:0] acc_at(input int i);
    return (i < acc.size()) ? {24'b0, acc[i]} : 32'hdead;
  endfunction
  initial begin
    bus.start = 0;
    bus.stop = 0;
    bus.out_ready = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    #1;
    check("rst_addr", bus.imem_addr, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_instr", bus.out_instr, 0);
    check("rst_pc", bus.out_pc, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (10) step();
    check("idle_addr", bus.imem_addr, 0);
    check("idle_valid", bus.out_valid, 0);
    // streaming
    bus.out_ready = 1;
    bus.start = 1;
    step();
    bus.start = 0;
    check("st_e0_valid", bus.out_valid, 0);
    check("st_e0_addr", bus.imem_addr, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("st_valid", bus.out_valid, 1);
      check("st_pc", bus.out_pc, 4 * i);
      check("st_instr", bus.out_instr, 4 * i);
    end
    bus.stop = 1;
    step();
    bus.stop = 0;
    check("stop_valid", bus.out_valid, 0);
    check("stop_addr", bus.imem_addr, 16);
    step();
    check("stop_hold", bus.imem_addr, 16);
    // backpressure
    pulse_rst();
    bus.out_ready = 0;
    bus.start = 1;
    step();
    bus.start = 0;
    repeat (6) step();
    check("bp_valid", bus.out_valid, 1);
    check("bp_head", bus.out_pc, 0);
    check("bp_addr", bus.imem_addr, 8);
    acc.delete();
    bus.out_ready = 1;
    repeat (4) step();
    check("bp_n", acc.size(), 4);
    for (int i = 0; i < 4; i++) check("bp_seq", acc_at(i), 4 * i);
    // jump predecode
    pulse_rst();
    acc.delete();
    seen48 = 0;
    bus.start = 1;
    bus.redirect_valid = 1;
    bus.redirect_pc = 40;
    step();
    bus.start = 0;
    bus.redirect_valid = 0;
    check("jr_addr", bus.imem_addr, 40);
    check("jr_valid", bus.out_valid, 0);
    step();
    check("j_pc40", bus.out_pc, 40);
    check("j_addr44", bus.imem_addr, 44);
    step();
    check("j_pc44", bus.out_pc, 44);
    check("j_instr", bus.out_instr, 32'h0800_0006);
    check("j_tgt", bus.imem_addr, 24);
    step();
    check("j_pc24", bus.out_pc, 24);
    step();
    check("j_pc28", bus.out_pc, 28);
    check("j_seq0", acc_at(0), 40);
    check("j_seq1", acc_at(1), 44);
    check("j_seq2", acc_at(2), 24);
    check("j_no48", seen48, 0);
    // redirect flush
    bus.out_ready = 0;
    bus.redirect_valid = 1;
    bus.redirect_pc = 8;
    step();
    bus.redirect_valid = 0;
    check("rd_flush", bus.out_valid, 0);
    check("rd_addr8", bus.imem_addr, 8);
    repeat (3) step();
    check("rd_head8", bus.out_pc, 8);
    check("rd_full_addr", bus.imem_addr, 16);
    acc.delete();
    bus.redirect_valid = 1;
    bus.redirect_pc = 8'h31;
    bus.out_ready = 1;
    step();
    bus.redirect_valid = 0;
    check("rd_valid", bus.out_valid, 0);
    check("rd_align", bus.imem_addr, 8'h30);
    step();
    check("rd_v30", bus.out_valid, 1);
    check("rd_pc30", bus.out_pc, 8'h30);
    check("rd_i30", bus.out_instr, 8'h30);
    step();
    check("rd_pc34", bus.out_pc, 8'h34);
    step();
    check("rd_n", acc.size(), 2);
    check("rd_seq0", acc_at(0), 8'h30);
    check("rd_seq1", acc_at(1), 8'h34);
    // wrap
    bus.redirect_valid = 1;
    bus.redirect_pc = 8'hfc;
    step();
    bus.redirect_valid = 0;
    acc.delete();
    step();
    check("w_pc", bus.out_pc, 8'hfc);
    check("w_addr", bus.imem_addr, 0);
    repeat (2) step();
    check("w_seq0", acc_at(0), 8'hfc);
    check("w_seq1", acc_at(1), 0);
    // asynchronous reset between edges
    check("ar_pre", bus.out_valid, 1);
    #3 rst = 1;
    #1;
    check("ar_valid", bus.out_valid, 0);
    check("ar_addr", bus.imem_addr, 0);
    check("ar_pc", bus.out_pc, 0);
    rst = 0;
    repeat (3) step();
    check("ar_idle_valid", bus.out_valid, 0);
    check("ar_idle_addr", bus.imem_addr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
